// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared command codes, FSM states and window-origin helper for lcd_img_proc
package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE    = 4'd0,
        CMD_UP       = 4'd1,
        CMD_DOWN     = 4'd2,
        CMD_LEFT     = 4'd3,
        CMD_RIGHT    = 4'd4,
        CMD_MAX      = 4'd5,
        CMD_MIN      = 4'd6,
        CMD_AVG      = 4'd7,
        CMD_CCW      = 4'd8,
        CMD_CW       = 4'd9,
        CMD_MIRROR_X = 4'd10,
        CMD_MIRROR_Y = 4'd11,
        CMD_ORIGIN   = 4'd12,
        CMD_THRESH   = 4'd13,
        CMD_NOP14    = 4'd14,
        CMD_NOP15    = 4'd15
    } cmd_e;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_LOAD  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    // Window origin coordinate that centres the 2x2 window along a dimension.
    function automatic int centre_of(input int dim);
        return dim / 2 - 1;
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// rtl/lcd_win_alu.sv - combinational 2x2 window pixel operator (max/min/avg/rotate/mirror/threshold)
module lcd_win_alu
    import lcd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] p0_i,
    input  logic [DW-1:0] p1_i,
    input  logic [DW-1:0] p2_i,
    input  logic [DW-1:0] p3_i,
    input  cmd_e          cmd_i,
    output logic [DW-1:0] n0_o,
    output logic [DW-1:0] n1_o,
    output logic [DW-1:0] n2_o,
    output logic [DW-1:0] n3_o,
    output logic          we_o
);

    logic [DW-1:0] max01, max23, max_all;
    logic [DW-1:0] min01, min23, min_all;
    logic [DW+1:0] sum;
    logic [DW-1:0] avg;

    // Window reductions shared by the fill commands; the sum has two guard bits so it never overflows.
    always_comb begin
        max01   = (p0_i > p1_i) ? p0_i : p1_i;
        max23   = (p2_i > p3_i) ? p2_i : p3_i;
        max_all = (max01 > max23) ? max01 : max23;
        min01   = (p0_i < p1_i) ? p0_i : p1_i;
        min23   = (p2_i < p3_i) ? p2_i : p3_i;
        min_all = (min01 < min23) ? min01 : min23;
        sum     = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
        avg     = DW'(sum >> 2);
    end

    // Select new window contents; moves, origin, write and no-ops leave the buffer untouched.
    always_comb begin
        n0_o = p0_i;
        n1_o = p1_i;
        n2_o = p2_i;
        n3_o = p3_i;
        we_o = 1'b1;
        case (cmd_i)
            CMD_MAX: begin
                n0_o = max_all; n1_o = max_all; n2_o = max_all; n3_o = max_all;
            end
            CMD_MIN: begin
                n0_o = min_all; n1_o = min_all; n2_o = min_all; n3_o = min_all;
            end
            CMD_AVG: begin
                n0_o = avg; n1_o = avg; n2_o = avg; n3_o = avg;
            end
            CMD_CCW: begin
                n0_o = p1_i; n1_o = p3_i; n3_o = p2_i; n2_o = p0_i;
            end
            CMD_CW: begin
                n0_o = p2_i; n1_o = p0_i; n3_o = p1_i; n2_o = p3_i;
            end
            CMD_MIRROR_X: begin
                n0_o = p2_i; n2_o = p0_i; n1_o = p3_i; n3_o = p1_i;
            end
            CMD_MIRROR_Y: begin
                n0_o = p1_i; n1_o = p0_i; n2_o = p3_i; n3_o = p2_i;
            end
            CMD_THRESH: begin
                n0_o = {DW{p0_i[DW-1]}};
                n1_o = {DW{p1_i[DW-1]}};
                n2_o = {DW{p2_i[DW-1]}};
                n3_o = {DW{p3_i[DW-1]}};
            end
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_img_proc.sv
// rtl/lcd_img_proc.sv - image buffer controller: ROM load, 2x2 window commands, RAM write-out
module lcd_img_proc
    import lcd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          busy,
    output logic          IROM_rd,
    output logic [AW-1:0] IROM_A,
    input  logic [DW-1:0] IROM_Q,
    output logic          IRAM_valid,
    output logic [AW-1:0] IRAM_A,
    output logic [DW-1:0] IRAM_D,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = AW - CW;

    localparam logic [AW-1:0] LAST_A   = AW'(N - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 2);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 2);
    localparam logic [RW-1:0] ROW_C    = RW'(centre_of(IMG_H));
    localparam logic [CW-1:0] COL_C    = CW'(centre_of(IMG_W));

    state_e        state_q, state_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] rom_a_q, rom_a_d;
    logic          cap_vld_q;
    logic [AW-1:0] cap_a_q;
    logic          wr_vld_q, wr_vld_d;
    logic [AW-1:0] wr_a_q, wr_a_d;
    logic [DW-1:0] wr_d_q, wr_d_d;
    logic          done_q, done_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    cmd_e          cmd_q, cmd_d;

    logic [DW-1:0] pix_q [N];

    // IMG_W is a power of two, so the row-major address is just {row, col}.
    logic [AW-1:0] a0, a1, a2, a3;
    assign a0 = {row_q, col_q};
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + ROW_STEP;
    assign a3 = a2 + AW'(1);

    logic [DW-1:0] n0, n1, n2, n3;
    logic          alu_we;

    lcd_win_alu #(.DW(DW)) u_alu (
        .p0_i  (pix_q[a0]),
        .p1_i  (pix_q[a1]),
        .p2_i  (pix_q[a2]),
        .p3_i  (pix_q[a3]),
        .cmd_i (cmd_q),
        .n0_o  (n0),
        .n1_o  (n1),
        .n2_o  (n2),
        .n3_o  (n3),
        .we_o  (alu_we)
    );

    // Next-state logic: load sequencing, command acceptance, window moves and write streaming.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        rom_a_d  = rom_a_q;
        wr_vld_d = wr_vld_q;
        wr_a_d   = wr_a_q;
        done_d   = done_q;
        row_d    = row_q;
        col_d    = col_q;
        cmd_d    = cmd_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_LOAD;
                rd_d    = 1'b1;
                rom_a_d = '0;
            end
            ST_LOAD: begin
                if (rd_q) begin
                    if (rom_a_q == LAST_A) begin
                        rd_d = 1'b0;
                    end else begin
                        rom_a_d = rom_a_q + AW'(1);
                    end
                end
                if (cap_vld_q && cap_a_q == LAST_A) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd_e'(cmd);
                    if (cmd_e'(cmd) == CMD_WRITE) begin
                        state_d  = ST_WRITE;
                        wr_vld_d = 1'b1;
                        wr_a_d   = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_UP:     if (row_q != '0)     row_d = row_q - RW'(1);
                    CMD_DOWN:   if (row_q < ROW_MAX) row_d = row_q + RW'(1);
                    CMD_LEFT:   if (col_q != '0)     col_d = col_q - CW'(1);
                    CMD_RIGHT:  if (col_q < COL_MAX) col_d = col_q + CW'(1);
                    CMD_ORIGIN: begin
                        row_d = ROW_C;
                        col_d = COL_C;
                    end
                    default: ;
                endcase
            end
            ST_WRITE: begin
                if (wr_a_q == LAST_A) begin
                    wr_vld_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end else begin
                    wr_a_d = wr_a_q + AW'(1);
                end
            end
            ST_FIN: ;
            default: state_d = ST_RESET;
        endcase
        wr_d_d = pix_q[wr_a_d];
    end

    // Control registers; every output is driven from here so reset gives a defined value on each.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            rd_q      <= 1'b0;
            rom_a_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            wr_vld_q  <= 1'b0;
            wr_a_q    <= '0;
            wr_d_q    <= '0;
            done_q    <= 1'b0;
            row_q     <= ROW_C;
            col_q     <= COL_C;
            cmd_q     <= CMD_NOP15;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            rom_a_q   <= rom_a_d;
            cap_vld_q <= rd_q;
            cap_a_q   <= rom_a_q;
            wr_vld_q  <= wr_vld_d;
            wr_a_q    <= wr_a_d;
            wr_d_q    <= wr_d_d;
            done_q    <= done_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cmd_q     <= cmd_d;
        end
    end

    // Pixel buffer: ROM capture lags the presented address by one cycle; window update during EXEC.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && cap_vld_q) begin
            pix_q[cap_a_q] <= IROM_Q;
        end else if (state_q == ST_EXEC && alu_we) begin
            pix_q[a0] <= n0;
            pix_q[a1] <= n1;
            pix_q[a2] <= n2;
            pix_q[a3] <= n3;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign IROM_rd    = rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = wr_vld_q;
    assign IRAM_A     = wr_a_q;
    assign IRAM_D     = wr_d_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_img_proc.sv
// tb/tb_lcd_img_proc.sv - self-checking bench for lcd_img_proc (8x8x8 and 4x4x10 instances)
module tb_lcd_img_proc;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv;
    logic       sel;
    logic [3:0] cmd;
    logic       cv_a, cv_b;

    logic       busy_a, rd_a, rv_a, done_a;
    logic [5:0] ia_a, ra_a;
    logic [7:0] q_a, d_a;

    logic       busy_b, rd_b, rv_b, done_b;
    logic [3:0] ia_b, ra_b;
    logic [9:0] q_b, d_b;

    logic       busy_s, rd_s, rv_s, done_s;
    logic [5:0] ia_s, ra_s;
    logic [9:0] d_s;

    logic [9:0] rom [64];

    int checks = 0;
    int errors = 0;

    int m_w, m_h, m_dw, m_n, m_mask, m_r, m_c;
    int m_buf [64];

    always #5 clk = ~clk;

    assign cv_a   = cv & ~sel;
    assign cv_b   = cv & sel;
    assign busy_s = sel ? busy_b : busy_a;
    assign rd_s   = sel ? rd_b : rd_a;
    assign rv_s   = sel ? rv_b : rv_a;
    assign done_s = sel ? done_b : done_a;
    assign ia_s   = sel ? {2'b00, ia_b} : ia_a;
    assign ra_s   = sel ? {2'b00, ra_b} : ra_a;
    assign d_s    = sel ? d_b : {2'b00, d_a};

    always @(posedge clk) begin
        q_a <= rom[ia_a][7:0];
        q_b <= rom[ia_b];
    end

    lcd_img_proc u_a (
        .clk(clk), .reset(rst), .cmd(cmd), .cmd_valid(cv_a), .busy(busy_a),
        .IROM_rd(rd_a), .IROM_A(ia_a), .IROM_Q(q_a),
        .IRAM_valid(rv_a), .IRAM_A(ra_a), .IRAM_D(d_a), .done(done_a)
    );

    lcd_img_proc #(.IMG_W(4), .IMG_H(4), .DW(10)) u_b (
        .clk(clk), .reset(rst), .cmd(cmd), .cmd_valid(cv_b), .busy(busy_b),
        .IROM_rd(rd_b), .IROM_A(ia_b), .IROM_Q(q_b),
        .IRAM_valid(rv_b), .IRAM_A(ra_b), .IRAM_D(d_b), .done(done_b)
    );

    task automatic set_cfg(input bit s);
        sel    = s;
        m_w    = s ? 4 : 8;
        m_h    = m_w;
        m_dw   = s ? 10 : 8;
        m_n    = m_w * m_h;
        m_mask = (1 << m_dw) - 1;
    endtask

    task automatic model_apply(input int c);
        int idx [4];
        int v [4];
        int nv [4];
        int src [4];
        int ext;
        idx[0] = m_r * m_w + m_c;
        idx[1] = idx[0] + 1;
        idx[2] = idx[0] + m_w;
        idx[3] = idx[2] + 1;
        for (int i = 0; i < 4; i++) begin
            v[i]  = m_buf[idx[i]];
            nv[i] = v[i];
        end
        src = '{0, 1, 2, 3};
        case (c)
            1: if (m_r > 0) m_r--;
            2: if (m_r < m_h - 2) m_r++;
            3: if (m_c > 0) m_c--;
            4: if (m_c < m_w - 2) m_c++;
            5: begin
                ext = v[0];
                for (int i = 1; i < 4; i++) if (v[i] > ext) ext = v[i];
                for (int i = 0; i < 4; i++) nv[i] = ext;
            end
            6: begin
                ext = v[0];
                for (int i = 1; i < 4; i++) if (v[i] < ext) ext = v[i];
                for (int i = 0; i < 4; i++) nv[i] = ext;
            end
            7: begin
                ext = (v[0] + v[1] + v[2] + v[3]) / 4;
                for (int i = 0; i < 4; i++) nv[i] = ext;
            end
            8:  src = '{1, 3, 0, 2};
            9:  src = '{2, 0, 3, 1};
            10: src = '{2, 3, 0, 1};
            11: src = '{1, 0, 3, 2};
            12: begin
                m_r = m_h / 2 - 1;
                m_c = m_w / 2 - 1;
            end
            13: for (int i = 0; i < 4; i++) nv[i] = (v[i] >= (1 << (m_dw - 1))) ? m_mask : 0;
            default: ;
        endcase
        if (c >= 8 && c <= 11) for (int i = 0; i < 4; i++) nv[i] = v[src[i]];
        for (int i = 0; i < 4; i++) m_buf[idx[i]] = nv[i];
    endtask

    task automatic reset_and_load();
        int cyc;
        int bad;
        cv = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < m_n; k++) m_buf[k] = int'(rom[k]) & m_mask;
        m_r = m_h / 2 - 1;
        m_c = m_w / 2 - 1;
        cyc = 0;
        bad = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            if (cyc < m_n) begin
                if (rd_s !== 1'b1 || ia_s !== 6'(cyc)) bad++;
            end else if (rd_s !== 1'b0) begin
                bad++;
            end
            cyc++;
            if (busy_s === 1'b0) break;
        end
        checks++;
        if (cyc != m_n + 2) begin
            errors++;
            $display("FAIL load_busy_cycles got %0d want %0d", cyc, m_n + 2);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_rom_sequence bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic send_cmd(input int c);
        cmd = 4'(c);
        cv  = 1'b1;
        @(posedge clk); #1 cv = 1'b0;
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("FAIL cmd_busy_rise cmd=%0d got %b want 1", c, busy_s);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b0) begin
            errors++;
            $display("FAIL cmd_busy_fall cmd=%0d got %b want 0", c, busy_s);
        end
        model_apply(c);
    endtask

    task automatic write_and_check(input string tag);
        cmd = 4'd0;
        cv  = 1'b1;
        @(posedge clk); #1 cv = 1'b0;
        for (int k = 0; k < m_n; k++) begin
            checks++;
            if (rv_s !== 1'b1 || ra_s !== 6'(k) || d_s !== 10'(m_buf[k])) begin
                errors++;
                $display("FAIL %s pix%0d got valid=%b addr=%0d data=%0d want valid=1 addr=%0d data=%0d",
                         tag, k, rv_s, ra_s, d_s, k, m_buf[k]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rv_s !== 1'b0 || done_s !== 1'b1 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL %s write_end got valid=%b done=%b busy=%b want 0 1 1", tag, rv_s, done_s, busy_s);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b1 || rv_s !== 1'b0) begin
            errors++;
            $display("FAIL %s fin_sticky got done=%b busy=%b valid=%b want 1 1 0", tag, done_s, busy_s, rv_s);
        end
    endtask

    task automatic test_reset();
        set_cfg(1'b0);
        cv = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_s !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy_s); end
        checks++;
        if (rd_s !== 1'b0 || ia_s !== 6'd0) begin
            errors++; $display("FAIL reset_irom got rd=%b addr=%0d want 0 0", rd_s, ia_s);
        end
        checks++;
        if (rv_s !== 1'b0 || ra_s !== 6'd0 || d_s !== 10'd0) begin
            errors++; $display("FAIL reset_iram got valid=%b addr=%0d data=%0d want 0 0 0", rv_s, ra_s, d_s);
        end
        checks++;
        if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_s); end
    endtask

    task automatic test_load_write();
        set_cfg(1'b0);
        for (int k = 0; k < 64; k++) rom[k] = 10'(k);
        reset_and_load();
        write_and_check("load_write");
    endtask

    task automatic test_max_avg();
        set_cfg(1'b0);
        for (int k = 0; k < 64; k++) rom[k] = 10'(k);
        reset_and_load();
        send_cmd(5);
        write_and_check("max_centre");
        reset_and_load();
        send_cmd(7);
        write_and_check("avg_centre");
    endtask

    task automatic test_edge_clamp();
        set_cfg(1'b0);
        for (int k = 0; k < 64; k++) rom[k] = 10'(k);
        reset_and_load();
        repeat (5) send_cmd(1);
        send_cmd(5);
        repeat (5) send_cmd(3);
        send_cmd(6);
        repeat (6) send_cmd(2);
        repeat (7) send_cmd(4);
        send_cmd(7);
        write_and_check("edge_clamp");
    endtask

    task automatic test_rotate_mirror_thresh();
        set_cfg(1'b0);
        for (int k = 0; k < 64; k++) rom[k] = 10'($urandom_range(0, 255));
        reset_and_load();
        send_cmd(8);
        send_cmd(9);
        send_cmd(10);
        send_cmd(10);
        send_cmd(11);
        send_cmd(12);
        write_and_check("rotate_mirror");
        rom[27] = 10'd127;
        rom[28] = 10'd128;
        rom[35] = 10'd0;
        rom[36] = 10'd255;
        reset_and_load();
        send_cmd(13);
        send_cmd(14);
        send_cmd(15);
        write_and_check("thresh");
    endtask

    task automatic test_handshake();
        set_cfg(1'b0);
        for (int k = 0; k < 64; k++) rom[k] = 10'($urandom_range(0, 255));
        reset_and_load();
        cmd = 4'd4;
        cv  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 7) cv = 1'b0;
            checks++;
            if (busy_s !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL held_valid_busy cycle%0d got %b want %b", i, busy_s, (i % 2 == 0));
            end
            if (i % 2 == 1) model_apply(4);
        end
        cmd = 4'd6;
        cv  = 1'b1;
        @(posedge clk); #1 cmd = 4'd3;
        checks++;
        if (busy_s !== 1'b1) begin errors++; $display("FAIL pulse_busy_rise got %b want 1", busy_s); end
        @(posedge clk); #1 cv = 1'b0;
        checks++;
        if (busy_s !== 1'b0) begin errors++; $display("FAIL pulse_busy_fall got %b want 0", busy_s); end
        model_apply(6);
        @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b0) begin errors++; $display("FAIL pulse_ignored got busy=%b want 0", busy_s); end
        send_cmd(5);
        write_and_check("handshake");
    endtask

    task automatic test_random();
        set_cfg(1'b0);
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 64; k++) rom[k] = 10'($urandom_range(0, 255));
            reset_and_load();
            for (int j = 0; j < 24; j++) send_cmd($urandom_range(1, 15));
            write_and_check("random");
        end
    endtask

    task automatic test_small_params();
        set_cfg(1'b1);
        for (int k = 0; k < 16; k++) rom[k] = 10'($urandom_range(0, 1023));
        reset_and_load();
        send_cmd(5);
        write_and_check("small_max_centre");
        reset_and_load();
        send_cmd(13);
        send_cmd(4);
        send_cmd(8);
        cmd = 4'd0;
        cv  = 1'b1;
        @(posedge clk); #1 cv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rv_s !== 1'b1 || ra_s !== 6'(k) || d_s !== 10'(m_buf[k])) begin
                errors++;
                $display("FAIL small_partial_write pix%0d got valid=%b addr=%0d data=%0d want 1 %0d %0d",
                         k, rv_s, ra_s, d_s, k, m_buf[k]);
            end
            if (k < 7) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rv_s !== 1'b0 || ra_s !== 6'd0 || d_s !== 10'd0) begin
            errors++; $display("FAIL midwrite_reset_iram got valid=%b addr=%0d data=%0d want 0 0 0", rv_s, ra_s, d_s);
        end
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0 || rd_s !== 1'b0) begin
            errors++; $display("FAIL midwrite_reset_ctrl got busy=%b done=%b rd=%b want 1 0 0", busy_s, done_s, rd_s);
        end
        reset_and_load();
        send_cmd(11);
        send_cmd(1);
        send_cmd(7);
        write_and_check("small_after_reset");
        set_cfg(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cv  = 1'b0;
        cmd = 4'd0;
        sel = 1'b0;
        test_reset();
        test_load_write();
        test_max_avg();
        test_edge_clamp();
        test_rotate_mirror_thresh();
        test_handshake();
        test_random();
        test_small_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_img_proc.md
# lcd_img_proc

Parametrised image-processing controller for the LCD path. It loads a `IMG_W` x `IMG_H` image of `DW`-bit pixels from the image ROM into an internal buffer, and applies host commands to a movable 2x2 operation window. The commands are shift, max/min/average fill, rotate, mirror, and the new origin/threshold commands. On the write command it streams the buffer to the image RAM. It replaces the fixed 8x8 controller and adds a real command handshake, a defined reset state on every output, and size/width generics.

## Interface
Parameters:
- `IMG_W`, 8: image width in pixels, power of two, ≥2
- `IMG_H`, 8: image height in pixels, ≥2
- `DW`, 8: pixel width in bits
- `AW`, $clog2(IMG_W*IMG_H): pixel address width

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `cmd`  in  4  command code; sampled only on acceptance
- `cmd_valid`  in  1  command request
- `busy`  out  1  high means no command can be accepted
- `IROM_rd`  out  1  ROM read enable
- `IROM_A`  out  AW  ROM address
- `IROM_Q`  in  DW  ROM data; holds the data for the address presented in the previous cycle
- `IRAM_valid`  out  1  RAM write strobe
- `IRAM_A`  out  AW  RAM address
- `IRAM_D`  out  DW  RAM data
- `done`  out  1  image written; sticky until `reset`

## Operation
- Buffer: `IMG_W*IMG_H` entries of `DW` bits, row-major.
- Window origin (r,c): r ∈ [0,IMG_H-2], c ∈ [0,IMG_W-2]. The window covers pixels P0=(r,c), P1=(r,c+1), P2=(r+1,c), P3=(r+1,c+1).
- Reset origin is the centre: r=IMG_H/2-1, c=IMG_W/2-1.
- Command codes:
  - 0 WRITE
  - 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT: move by 1; clamp silently at the edge (no wrap)
  - 5 MAX, 6 MIN: all four pixels take the max/min of the window
  - 7 AVG: all four pixels take (P0+P1+P2+P3)>>2, summed in DW+2 bits, truncated
  - 8 CCW rotate: P0←P1, P1←P3, P3←P2, P2←P0
  - 9 CW rotate: P0←P2, P1←P0, P3←P1, P2←P3
  - 10 MIRROR_X: swap rows (P0↔P2, P1↔P3)
  - 11 MIRROR_Y: swap columns (P0↔P1, P2↔P3)
  - 12 ORIGIN: window returns to the centre
  - 13 THRESH: each pixel becomes all-ones if ≥ 2^(DW-1), else 0
  - 14, 15: no-op; accepted and completed like a one-cycle command
- FSM states:
  - RESET → LOAD on the first cycle with `reset` low
  - LOAD → IDLE after the last pixel is captured
  - IDLE → EXEC when a command is accepted
  - EXEC → IDLE after one cycle
  - IDLE → WRITE when WRITE is accepted
  - WRITE → FIN after the last pixel is output
  - FIN is absorbing

## Timing
- Reset values while `reset` is high: `busy`=1, `IROM_rd`=0, `IROM_A`=0, `IRAM_valid`=0, `IRAM_A`=0, `IRAM_D`=0, `done`=0, window at the centre. Buffer contents are don't-care.
- `reset` asserted in any state, including mid-WRITE, returns the block to these values on the next edge. Loading then restarts from address 0.
- LOAD:
  - `IROM_rd`=1 with `IROM_A` = 0,1,…,N-1 on consecutive cycles, where N = IMG_W*IMG_H.
  - Pixel k is captured one cycle after address k is presented.
  - `IROM_rd` drops once address N-1 has been presented.
  - `busy` falls the cycle after pixel N-1 is captured, i.e. N+2 cycles after reset is released.
- Acceptance happens when `cmd_valid` && !`busy` at an edge.
  - `busy` rises on that edge; EXEC takes one cycle; `busy` falls on the next edge.
  - The new buffer and window state is visible when `busy` falls.
  - `cmd_valid` while `busy`=1 is ignored; there is no queueing.
- WRITE:
  - On acceptance, `busy` rises.
  - For N consecutive cycles: `IRAM_valid`=1, `IRAM_A`=k, `IRAM_D`=buffer[k], for k = 0…N-1.
  - The next cycle: `IRAM_valid`=0, `done`=1.
  - `busy` stays 1 in FIN.

## Structure
- Package `lcd_pkg` holds:
  - the `cmd_e` enum (4-bit codes above)
  - the `state_e` FSM enum
  - a function for the centre origin
- Sub-module `lcd_win_alu`: combinational. Inputs P0..P3 and `cmd`; outputs four new pixel values and a write enable. It covers MAX/MIN/AVG/rotations/mirrors/THRESH, parameterised by `DW`.
- The top level holds the FSM, the counters, the window origin and the buffer.

## Test plan
- Load + write, default params, ROM[k]=k: write immediately after `busy` falls → `IRAM_D`=k at `IRAM_A`=k for k=0…63, then `done`=1 and `busy` stays 1.
- Default params, ROM[k]=k: MAX at the centre → pixels 27, 28, 35, 36 all become 36. Then AVG on a fresh load → all become 31 ((27+28+35+36)>>2 = 126>>2).
- Edge clamp: UP ×5, then MAX → window at r=0, c=3; pixels 3, 4, 11, 12 become 12. Then LEFT ×5, MIN → pixels 0, 1, 8, 9 become 0.
- CCW, then CW, on the centre window → buffer unchanged. MIRROR_X ×2 → buffer unchanged. THRESH with DW=8 on values 127, 128, 0, 255 → 0, 255, 0, 255.
- Handshake: hold `cmd_valid`=1 with RIGHT continuously → exactly one move per two cycles. `cmd_valid` pulsed while `busy`=1 → no effect.
- IMG_W=IMG_H=4, DW=10: centre origin is address 5. Reset asserted mid-WRITE at k=7 → `IRAM_valid`=0 next cycle, then a full reload (busy for 18 cycles).
